oh_ser2par_stream: RTL and testbench
====================================

# oh_ser2par_stream

Parametrised serial-to-parallel deserializer with word framing, output buffering and a valid/ready handshake. It accepts SW-bit beats qualified by a valid strobe and assembles PW/SW beats into one PW-bit word, MSB-first or LSB-first. It hands completed words downstream through a registered output slot, so assembly continues while a word waits to be consumed. The block sits between a link/PHY receive path and packet-level logic, replacing free-running shifters where framing and backpressure are required.

## Interface
- PW, 64, parallel word width in bits; must be an integer multiple of SW.
- SW, 1, serial beat width in bits; PW/SW must be >= 2.
- N (localparam), PW/SW, beats per word.
- CW (localparam), $clog2(N), beat counter width.

- clk  input  1  sampling clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  SW  serial beat data.
- valid_in  input  1  din holds a valid beat this cycle.
- lsbfirst  input  1  1: first beat lands in dout[SW-1:0]; 0: first beat lands in dout[PW-1:PW-SW].
- sync  input  1  frame restart: discard partial word, clear overflow.
- dout  output  PW  assembled word; valid while valid_out=1.
- valid_out  output  1  output slot holds an unconsumed word.
- ready_in  input  1  downstream accepts dout when valid_out & ready_in.
- overflow  output  1  sticky: a completed word was dropped.
- busy  output  1  partial word in progress (beat count != 0).

## Operation
- State: shift register shreg[PW-1:0], beat counter cnt[CW-1:0] (0..N-1), output register dout, valid_out, overflow.
- Beat accept (valid_in=1): lsbfirst=1 gives next = {din, shreg[PW-1:SW]}; lsbfirst=0 gives next = {shreg[PW-SW-1:0], din}. shreg <= next. cnt increments; at cnt=N-1 it wraps to 0 (compare against N-1; N need not be a power of two).
- lsbfirst is applied per beat. Changing it mid-word is legal, but the word content is then unspecified. Counter behaviour is unaffected.
- Word complete: valid_in=1 and cnt=N-1.
  - If the slot is free (valid_out=0) or drained this cycle (valid_out & ready_in), then dout <= next and valid_out <= 1.
  - Otherwise the word is dropped, overflow <= 1, and dout/valid_out are unchanged.
- Drain: valid_out & ready_in with no word completing gives valid_out <= 0. dout keeps its last value.
- Drain and load in the same cycle: valid_out stays 1 and dout takes the new word. No bubble.
- ready_in while valid_out=0 is ignored.
- sync=1: shreg <= 0, cnt <= 0, overflow <= 0. The output slot is unaffected.
  - sync with valid_in in the same cycle: the beat is taken as beat 0 of the new word (cnt <= 1; shreg holds only that beat in the proper position).
  - sync has priority over word completion: no word is emitted in that cycle.
- busy = (cnt != 0).

## Timing
- Reset values: shreg=0, cnt=0, dout=0, valid_out=0, overflow=0, busy=0.
- Reset asserted mid-word or with a word pending discards all state immediately (asynchronous). First beat after release is beat 0.
- Latency: dout/valid_out are registered. They update on the same rising edge that samples the N-th beat and are visible in the following cycle.
- Throughput: one word per N accepted beats. valid_in may stay high indefinitely. Gaps in valid_in stall assembly without loss.
- Downstream has N cycles (at full beat rate) to consume a word before the next word completes and triggers overflow.
- overflow rises the cycle after the dropping edge. It falls only on reset or sync.

## Test plan
- PW=8, SW=1, lsbfirst=0, continuous bits 1,1,0,0,0,0,0,0, ready_in=1 -> dout=0xC0, valid_out=1 for exactly one cycle after the 8th beat edge; busy high for beats 1-7.
- Same bits, lsbfirst=1 -> dout=0x03. Repeat with valid_in toggling 1/0 -> identical dout, completion after 8 accepted beats.
- PW=16, SW=4, lsbfirst=0, nibbles 0xA,0xB,0xC,0xD -> dout=0xABCD; lsbfirst=1 -> dout=0xDCBA.
- PW=8, SW=1, ready_in=0, stream two words 0x5A then 0x3C -> dout stays 0x5A, valid_out=1, overflow=1 after the 16th beat. Assert ready_in -> valid_out=0 next cycle, overflow stays 1. Pulse sync -> overflow=0.
- Back-to-back words 0x11, 0x22, with ready_in asserted on the cycle the second word completes -> dout switches 0x11 to 0x22 with valid_out held 1, overflow=0.
- Feed 3 beats, then sync together with a valid beat, then 7 more beats (PW=8, SW=1, bits 1,0,0,0,0,0,0,1 from sync) -> dout=0x81. Separately, assert reset after 5 beats -> all outputs 0; the next 8 beats form a clean word.

Source files
------------

// File: rtl/oh_ser2par_stream_if.sv
// Stream-side bundle for oh_ser2par_stream: serial beat input, framing controls,
// parallel word output with valid/ready handshake, and status flags.
`timescale 1ns/1ps
interface oh_ser2par_stream_if #(
  parameter int unsigned PW = 64,
  parameter int unsigned SW = 1
);
  logic [SW-1:0] din;
  logic          valid_in;
  logic          lsbfirst;
  logic          sync;
  logic [PW-1:0] dout;
  logic          valid_out;
  logic          ready_in;
  logic          overflow;
  logic          busy;

  // Deserializer side
  modport slave (
    input  din, valid_in, lsbfirst, sync, ready_in,
    output dout, valid_out, overflow, busy
  );

  // Driver/consumer side
  modport master (
    output din, valid_in, lsbfirst, sync, ready_in,
    input  dout, valid_out, overflow, busy
  );
endinterface

// File: rtl/oh_ser2par_stream.sv
// Serial-to-parallel deserializer: assembles PW/SW beats into a PW-bit word and hands it
// downstream through a registered output slot with valid/ready handshake.
`timescale 1ns/1ps
module oh_ser2par_stream #(
  parameter int unsigned PW = 64,
  parameter int unsigned SW = 1
) (
  input logic               clk,
  input logic               reset,
  oh_ser2par_stream_if.slave s
);
  localparam int unsigned N  = PW / SW;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LastBeat = CW'(N - 1);

  logic [PW-1:0] shreg_q, shreg_d;
  logic [PW-1:0] dout_q, dout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_out_q, valid_out_d;
  logic          overflow_q, overflow_d;
  logic [PW-1:0] shift_base;
  logic [PW-1:0] beat_word;
  logic          word_done;
  logic          slot_free;

  // Shift one beat into the word; sync drops history so the beat lands as beat 0
  always_comb begin
    shift_base = s.sync ? '0 : shreg_q;
    if (s.lsbfirst) begin
      beat_word = {s.din, shift_base[PW-1:SW]};
    end else begin
      beat_word = {shift_base[PW-SW-1:0], s.din};
    end
  end

  // Beat counting, word completion, output slot load/drain and overflow tracking
  always_comb begin
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    valid_out_d = valid_out_q;
    overflow_d  = overflow_q;
    word_done   = s.valid_in && !s.sync && (cnt_q == LastBeat);
    slot_free   = !valid_out_q || s.ready_in;

    if (s.sync) begin
      shreg_d    = s.valid_in ? beat_word : '0;
      cnt_d      = s.valid_in ? CW'(1) : '0;
      overflow_d = 1'b0;
    end else if (s.valid_in) begin
      shreg_d = beat_word;
      cnt_d   = word_done ? '0 : cnt_q + CW'(1);
    end

    // Load and drain in one cycle keeps valid_out high: no bubble
    if (word_done && slot_free) begin
      dout_d      = beat_word;
      valid_out_d = 1'b1;
    end else if (word_done) begin
      overflow_d = 1'b1;
    end else if (valid_out_q && s.ready_in) begin
      valid_out_d = 1'b0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q     <= '0;
      cnt_q       <= '0;
      dout_q      <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      valid_out_q <= valid_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign s.dout      = dout_q;
  assign s.valid_out = valid_out_q;
  assign s.overflow  = overflow_q;
  assign s.busy      = (cnt_q != '0);
endmodule

// File: tb/tb_oh_ser2par_stream.sv
// Directed bench for oh_ser2par_stream: an 8/1 and a 16/4 instance, expected words queued
// as stimulus is driven and compared when each new word appears on the output slot.
`timescale 1ns/1ps
module tb_oh_ser2par_stream;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  oh_ser2par_stream_if #(.PW(8), .SW(1)) i8 ();
  oh_ser2par_stream_if #(.PW(16), .SW(4)) i16 ();

  oh_ser2par_stream #(.PW(8), .SW(1)) u8 (
    .clk   (clk),
    .reset (reset),
    .s     (i8.slave)
  );

  oh_ser2par_stream #(.PW(16), .SW(4)) u16 (
    .clk   (clk),
    .reset (reset),
    .s     (i16.slave)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0]  q8[$];
  logic [15:0] q16[$];
  int cnt8 = 0;
  int cnt16 = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h required=%h", tag, obs, exp);
    end
  endtask

  // One clock of the 8-bit instance, then scoreboard and busy checks
  task automatic step8(input logic b, input logic v, input logic rdy, input logic syn);
    logic vo_b;
    logic rdy_b;
    logic [7:0] exp;
    i8.din      = b;
    i8.valid_in = v;
    i8.ready_in = rdy;
    i8.sync     = syn;
    vo_b  = i8.valid_out;
    rdy_b = rdy;
    if (syn) cnt8 = v ? 1 : 0;
    else if (v) cnt8 = (cnt8 == 7) ? 0 : cnt8 + 1;
    @(posedge clk);
    #1;
    if (i8.valid_out && (!vo_b || rdy_b)) begin
      checks++;
      assert (q8.size() != 0) else begin
        errors++;
        $error("FAIL spurious_word8 observed=%h required=none", i8.dout);
      end
      if (q8.size() != 0) begin
        exp = q8.pop_front();
        chk("word8", 64'(i8.dout), 64'(exp));
      end
    end
    chk("busy8", 64'(i8.busy), 64'(cnt8 != 0));
    i8.sync = 1'b0;
  endtask

  task automatic step16(input logic [3:0] nib, input logic v);
    logic vo_b;
    logic [15:0] exp;
    i16.din      = nib;
    i16.valid_in = v;
    i16.ready_in = 1'b1;
    vo_b = i16.valid_out;
    if (v) cnt16 = (cnt16 == 3) ? 0 : cnt16 + 1;
    @(posedge clk);
    #1;
    if (i16.valid_out) begin
      checks++;
      assert (q16.size() != 0) else begin
        errors++;
        $error("FAIL spurious_word16 observed=%h required=none", i16.dout);
      end
      if (q16.size() != 0) begin
        exp = q16.pop_front();
        chk("word16", 64'(i16.dout), 64'(exp));
      end
    end
    chk("busy16", 64'(i16.busy), 64'(cnt16 != 0));
    if (vo_b) chk("drain16", 64'(i16.valid_out), 64'(v && cnt16 == 0));
  endtask

  // bits[7] is driven first; gap inserts an idle cycle after every beat
  task automatic send8(input logic [7:0] bits, input logic gap, input logic rdy);
    for (int i = 7; i >= 0; i--) begin
      step8(bits[i], 1'b1, rdy, 1'b0);
      if (gap) step8(1'b0, 1'b0, rdy, 1'b0);
    end
  endtask

  task automatic send16(input logic [15:0] nibs);
    for (int i = 3; i >= 0; i--) step16(nibs[i*4 +: 4], 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    i8.din = '0;  i8.valid_in = 1'b0;  i8.lsbfirst = 1'b0;  i8.sync = 1'b0;  i8.ready_in = 1'b1;
    i16.din = '0; i16.valid_in = 1'b0; i16.lsbfirst = 1'b0; i16.sync = 1'b0; i16.ready_in = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_dout8", 64'(i8.dout), 64'h0);
    chk("rst_valid8", 64'(i8.valid_out), 64'h0);
    chk("rst_ovf8", 64'(i8.overflow), 64'h0);
    chk("rst_busy8", 64'(i8.busy), 64'h0);
    chk("rst_dout16", 64'(i16.dout), 64'h0);
    reset = 1'b0;

    // MSB-first 1,1,0,0,0,0,0,0 -> 0xC0, valid for exactly one cycle
    i8.lsbfirst = 1'b0;
    q8.push_back(8'hC0);
    send8(8'b1100_0000, 1'b0, 1'b1);
    chk("c0_valid", 64'(i8.valid_out), 64'h1);
    step8(1'b0, 1'b0, 1'b1, 1'b0);
    chk("c0_one_cycle", 64'(i8.valid_out), 64'h0);
    chk("c0_dout_kept", 64'(i8.dout), 64'hC0);

    // Same bits LSB-first -> 0x03, continuous then with valid_in gaps
    i8.lsbfirst = 1'b1;
    q8.push_back(8'h03);
    send8(8'b1100_0000, 1'b0, 1'b1);
    step8(1'b0, 1'b0, 1'b1, 1'b0);
    q8.push_back(8'h03);
    send8(8'b1100_0000, 1'b1, 1'b1);
    chk("gap_drained", 64'(i8.valid_out), 64'h0);

    // 16/4: nibbles A,B,C,D
    q16.push_back(16'hABCD);
    send16(16'hABCD);
    step16(4'h0, 1'b0);
    i16.lsbfirst = 1'b1;
    q16.push_back(16'hDCBA);
    send16(16'hABCD);
    step16(4'h0, 1'b0);

    // Overflow: 0x5A held, 0x3C dropped
    i8.lsbfirst = 1'b0;
    q8.push_back(8'h5A);
    send8(8'h5A, 1'b0, 1'b0);
    chk("ovf_before", 64'(i8.overflow), 64'h0);
    send8(8'h3C, 1'b0, 1'b0);
    chk("ovf_dout", 64'(i8.dout), 64'h5A);
    chk("ovf_valid", 64'(i8.valid_out), 64'h1);
    chk("ovf_set", 64'(i8.overflow), 64'h1);
    step8(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_drain_valid", 64'(i8.valid_out), 64'h0);
    chk("ovf_sticky", 64'(i8.overflow), 64'h1);
    step8(1'b0, 1'b0, 1'b1, 1'b1);
    chk("ovf_sync_clear", 64'(i8.overflow), 64'h0);

    // Back-to-back 0x11, 0x22; ready only on the cycle 0x22 completes
    q8.push_back(8'h11);
    q8.push_back(8'h22);
    send8(8'h11, 1'b0, 1'b0);
    for (int i = 7; i >= 1; i--) step8(1'(8'h22 >> i), 1'b1, 1'b0, 1'b0);
    chk("b2b_hold", 64'(i8.dout), 64'h11);
    step8(1'b0, 1'b1, 1'b1, 1'b0);
    chk("b2b_valid", 64'(i8.valid_out), 64'h1);
    chk("b2b_dout", 64'(i8.dout), 64'h22);
    chk("b2b_ovf", 64'(i8.overflow), 64'h0);
    step8(1'b0, 1'b0, 1'b1, 1'b0);

    // 3 stray beats, sync with a valid beat, then 7 beats -> 0x81
    for (int i = 0; i < 3; i++) step8(1'b1, 1'b1, 1'b1, 1'b0);
    q8.push_back(8'h81);
    step8(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step8(1'b0, 1'b1, 1'b1, 1'b0);
    step8(1'b1, 1'b1, 1'b1, 1'b0);
    step8(1'b0, 1'b0, 1'b1, 1'b0);

    // Reset with a word pending and 5 beats in progress, then a clean word
    q8.push_back(8'h96);
    send8(8'h96, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step8(1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    chk("arst_dout", 64'(i8.dout), 64'h0);
    chk("arst_valid", 64'(i8.valid_out), 64'h0);
    chk("arst_ovf", 64'(i8.overflow), 64'h0);
    chk("arst_busy", 64'(i8.busy), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cnt8 = 0;
    q8.push_back(8'hE7);
    send8(8'hE7, 1'b0, 1'b1);
    step8(1'b0, 1'b0, 1'b1, 1'b0);

    chk("q8_all_seen", 64'(q8.size()), 64'h0);
    chk("q16_all_seen", 64'(q16.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
